// File: rtl/dram_arb_pkg.sv
// Shared definitions for the two-port DRAM arbiter: sequencer states,
// default bus widths and requester port indices.
package dram_arb_pkg;

  localparam int AW_DEF   = 24;
  localparam int DW_DEF   = 24;
  localparam int PORT_IF  = 0;   // instruction fetch
  localparam int PORT_LSU = 1;   // load/store unit

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // One-hot response vector for a single port index
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. A lone requester always wins; on a tie the
// pointer port wins, and every accepted grant hands priority to the other port.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // Grant selection from current requests and priority pointer
  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // Priority passes to the port that did not just win
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = ~grant_o[1];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register, port 0 favoured out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port DRAM. Accepts one
// request at a time, strobes the DRAM for MEM_LAT cycles, and returns a
// one-cycle response pulse to the requester that won arbitration.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int DEPTH   = 1024,
  parameter int MEM_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req0_valid_i,
  input  logic          req0_we_i,
  input  logic [AW-1:0] req0_addr_i,
  input  logic [DW-1:0] req0_wdata_i,
  output logic          req0_ready_o,
  output logic          rsp0_valid_o,
  output logic [DW-1:0] rsp0_rdata_o,
  output logic          rsp0_err_o,
  input  logic          req1_valid_i,
  input  logic          req1_we_i,
  input  logic [AW-1:0] req1_addr_i,
  input  logic [DW-1:0] req1_wdata_i,
  output logic          req1_ready_o,
  output logic          rsp1_valid_o,
  output logic [DW-1:0] rsp1_rdata_o,
  output logic          rsp1_err_o,
  output logic          mem_write_o,
  output logic          mem_read_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          port_q, port_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_err_q, rsp_err_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic [1:0]    valid_s;
  logic [1:0]    grant_s;
  logic [1:0]    ready_s;
  logic          accept_s;
  logic          sel_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;
  logic          in_range_s;

  assign valid_s[PORT_IF]  = req0_valid_i;
  assign valid_s[PORT_LSU] = req1_valid_i;

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (valid_s),
    .advance_i (accept_s),
    .grant_o   (grant_s)
  );

  // Ready only in IDLE, and only to the arbitration winner
  always_comb begin
    if (state_q == ST_IDLE) begin
      ready_s = grant_s;
    end else begin
      ready_s = 2'b00;
    end
  end

  assign accept_s    = |(valid_s & ready_s);
  assign sel_s       = grant_s[PORT_LSU];
  assign sel_we_s    = sel_s ? req1_we_i    : req0_we_i;
  assign sel_addr_s  = sel_s ? req1_addr_i  : req0_addr_i;
  assign sel_wdata_s = sel_s ? req1_wdata_i : req0_wdata_i;
  assign in_range_s  = (sel_addr_s < AW'(DEPTH));

  // Sequencer next state: accept, strobe DRAM for MEM_LAT cycles, respond
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    port_d      = port_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 2'b00;
    rsp_err_d   = 2'b00;
    rdata0_d    = {DW{1'b0}};
    rdata1_d    = {DW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          we_d    = sel_we_s;
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          port_d  = sel_s;
          if (in_range_s) begin
            state_d = ST_ACCESS;
            rd_d    = ~sel_we_s;
            wr_d    = sel_we_s;
            cnt_d   = CW'(MEM_LAT - 1);
          end else begin
            // Out-of-range address: skip the DRAM entirely
            state_d     = ST_RESP;
            rsp_valid_d = port_onehot(sel_s);
            rsp_err_d   = port_onehot(sel_s);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d     = ST_RESP;
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          rsp_valid_d = port_onehot(port_q);
          if (port_q) begin
            rdata1_d = we_q ? {DW{1'b0}} : mem_rdata_i;
          end else begin
            rdata0_d = we_q ? {DW{1'b0}} : mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase
  end

  // Sequencer, DRAM pin and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= {AW{1'b0}};
      wdata_q     <= {DW{1'b0}};
      port_q      <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= {CW{1'b0}};
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 2'b00;
      rdata0_q    <= {DW{1'b0}};
      rdata1_q    <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      port_q      <= port_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign req0_ready_o = ready_s[PORT_IF];
  assign req1_ready_o = ready_s[PORT_LSU];
  assign rsp0_valid_o = rsp_valid_q[PORT_IF];
  assign rsp1_valid_o = rsp_valid_q[PORT_LSU];
  assign rsp0_err_o   = rsp_err_q[PORT_IF];
  assign rsp1_err_o   = rsp_err_q[PORT_LSU];
  assign rsp0_rdata_o = rdata0_q;
  assign rsp1_rdata_o = rdata1_q;
  assign mem_read_o   = rd_q;
  assign mem_write_o  = wr_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;

endmodule
